// File: rtl/vm2002_pkg.sv
// Shared types for the vending machine stock arbiter: purchase status codes,
// arbiter state encoding and the item code map.
package vm2002_pkg;

  typedef enum logic [1:0] {
    ST_AVAILABLE    = 2'd0,
    ST_OUT_OF_STOCK = 2'd1,
    ST_INSUFFICIENT = 2'd2,
    ST_ERROR        = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SUP_EXEC = 2'd1,
    VND_EXEC = 2'd2
  } arb_state_e;

  localparam logic [2:0] WATER  = 3'd0;
  localparam logic [2:0] SODA   = 3'd1;
  localparam logic [2:0] JUICE  = 3'd2;
  localparam logic [2:0] TEA    = 3'd3;
  localparam logic [2:0] COFFEE = 3'd4;
  localparam logic [2:0] CHIPS  = 3'd5;
  localparam logic [2:0] CANDY  = 3'd6;
  localparam logic [2:0] COOKIE = 3'd7;

endpackage

// File: rtl/vm2002_stock_arbiter_if.sv
// Restock and purchase handshake bundle. The requester side (supplier and
// vend engine) uses the master modport; the arbiter uses the slave modport.
interface vm2002_stock_arbiter_if;
  import vm2002_pkg::*;

  logic        sup_valid;
  logic [2:0]  sup_item;
  logic [3:0]  sup_count;
  logic [7:0]  sup_cost;
  logic        sup_ready;
  logic        sup_done;
  logic        sup_err;

  logic        vnd_valid;
  logic [2:0]  vnd_item;
  logic [15:0] vnd_amount;
  logic        vnd_ready;
  logic        vnd_done;
  status_e     vnd_status;
  logic [15:0] vnd_balance;
  logic [2:0]  vnd_product;

  modport master (
    output sup_valid, sup_item, sup_count, sup_cost,
    input  sup_ready, sup_done, sup_err,
    output vnd_valid, vnd_item, vnd_amount,
    input  vnd_ready, vnd_done, vnd_status, vnd_balance, vnd_product
  );

  modport slave (
    input  sup_valid, sup_item, sup_count, sup_cost,
    output sup_ready, sup_done, sup_err,
    input  vnd_valid, vnd_item, vnd_amount,
    output vnd_ready, vnd_done, vnd_status, vnd_balance, vnd_product
  );

endinterface

// File: rtl/vm2002_stock_table.sv
// Per-item {count, cost} register file: one write port, two combinational
// read ports (one for the executing operation, one for external queries).
module vm2002_stock_table #(
  parameter int NUM_ITEMS = 8,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_item,
  input  logic [CNT_W-1:0] wr_count,
  input  logic [7:0]       wr_cost,
  input  logic [2:0]       exec_item,
  output logic [CNT_W-1:0] exec_count,
  output logic [7:0]       exec_cost,
  input  logic [2:0]       qry_item,
  output logic [CNT_W-1:0] qry_count,
  output logic [7:0]       qry_cost
);

  logic [CNT_W-1:0] cnt_q  [NUM_ITEMS];
  logic [7:0]       cost_q [NUM_ITEMS];

  // Table storage; codes outside 0..NUM_ITEMS-1 never match a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        cnt_q[i]  <= '0;
        cost_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (wr_en && (wr_item == 3'(i))) begin
          cnt_q[i]  <= wr_count;
          cost_q[i] <= wr_cost;
        end
      end
    end
  end

  // Read muxes; an absent slot reads as empty and unpriced.
  always_comb begin
    exec_count = '0;
    exec_cost  = '0;
    qry_count  = '0;
    qry_cost   = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (exec_item == 3'(i)) begin
        exec_count = cnt_q[i];
        exec_cost  = cost_q[i];
      end
      if (qry_item == 3'(i)) begin
        qry_count = cnt_q[i];
        qry_cost  = cost_q[i];
      end
    end
  end

endmodule

// File: rtl/vm2002_stock_arbiter.sv
// Shares the stock tables between the supplier restock port and the vend
// purchase port, one operation at a time, with alternating tie-break.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a request; the only state that grants
// SUP_EXEC | restock read-modify-write, done pulse on the next cycle
// VND_EXEC | purchase checks and decrement, done pulse on the next cycle
module vm2002_stock_arbiter
  import vm2002_pkg::*;
#(
  parameter int NUM_ITEMS = 8,
  parameter int MAX_COUNT = 16,
  parameter int CNT_W     = 5
) (
  input  logic                   clk,
  input  logic                   hrst_n,
  vm2002_stock_arbiter_if.slave  bus,
  input  logic [2:0]             qry_item,
  output logic [CNT_W-1:0]       qry_count,
  output logic [7:0]             qry_cost
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_SUP  = SUP_EXEC;
  localparam logic [1:0] S_VND  = VND_EXEC;

  localparam logic [7:0]   ITEM_MASK = 8'((64'd1 << NUM_ITEMS) - 64'd1);
  localparam logic [CNT_W:0] MAX_SUM = MAX_COUNT[CNT_W:0];

  logic [1:0]       state_q;
  logic             prio_vnd_q;
  logic [2:0]       item_q;
  logic [3:0]       add_q;
  logic [7:0]       cost_q;
  logic [15:0]      amount_q;

  logic             sup_done_q, sup_err_q, vnd_done_q;
  status_e          vnd_status_q;
  logic [15:0]      vnd_balance_q;
  logic [2:0]       vnd_product_q;

  logic             sup_rdy, vnd_rdy;
  logic [CNT_W-1:0] exec_count;
  logic [7:0]       exec_cost;
  logic             item_ok;
  logic [CNT_W:0]   sum;
  logic             sup_fail;
  status_e          vnd_st;
  logic             wr_en;
  logic [CNT_W-1:0] wr_count;
  logic [7:0]       wr_cost;

  // Grant in IDLE only; on a tie the prio flag picks the winner.
  always_comb begin
    sup_rdy = 1'b0;
    vnd_rdy = 1'b0;
    if (state_q == S_IDLE) begin
      sup_rdy = bus.sup_valid && (!bus.vnd_valid || !prio_vnd_q);
      vnd_rdy = bus.vnd_valid && (!bus.sup_valid ||  prio_vnd_q);
    end
  end

  // Restock overflow and purchase decision, plus the resulting table write.
  always_comb begin
    item_ok  = ITEM_MASK[item_q];
    sum      = {1'b0, exec_count} + {{(CNT_W-3){1'b0}}, add_q};
    sup_fail = !item_ok || (sum > MAX_SUM);
    if (!item_ok || exec_cost == 8'd0)        vnd_st = ST_ERROR;
    else if (exec_count == '0)                vnd_st = ST_OUT_OF_STOCK;
    else if (amount_q < {8'd0, exec_cost})    vnd_st = ST_INSUFFICIENT;
    else                                      vnd_st = ST_AVAILABLE;
    wr_en    = 1'b0;
    wr_count = exec_count;
    wr_cost  = exec_cost;
    if (state_q == S_SUP && !sup_fail) begin
      wr_en    = 1'b1;
      wr_count = sum[CNT_W-1:0];
      wr_cost  = (cost_q != 8'd0) ? cost_q : exec_cost;
    end else if (state_q == S_VND && vnd_st == ST_AVAILABLE) begin
      wr_en    = 1'b1;
      wr_count = exec_count - CNT_W'(1);
    end
  end

  // Sequencer: latch the granted request, execute for one cycle, report.
  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q       <= S_IDLE;
      prio_vnd_q    <= 1'b0;
      item_q        <= '0;
      add_q         <= '0;
      cost_q        <= '0;
      amount_q      <= '0;
      sup_done_q    <= 1'b0;
      sup_err_q     <= 1'b0;
      vnd_done_q    <= 1'b0;
      vnd_status_q  <= ST_AVAILABLE;
      vnd_balance_q <= '0;
      vnd_product_q <= '0;
    end else begin
      sup_done_q <= 1'b0;
      vnd_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sup_rdy) begin
            item_q     <= bus.sup_item;
            add_q      <= bus.sup_count;
            cost_q     <= bus.sup_cost;
            prio_vnd_q <= 1'b1;
            state_q    <= S_SUP;
          end else if (vnd_rdy) begin
            item_q     <= bus.vnd_item;
            amount_q   <= bus.vnd_amount;
            prio_vnd_q <= 1'b0;
            state_q    <= S_VND;
          end
        end
        S_SUP: begin
          sup_done_q <= 1'b1;
          sup_err_q  <= sup_fail;
          state_q    <= S_IDLE;
        end
        S_VND: begin
          vnd_done_q    <= 1'b1;
          vnd_status_q  <= vnd_st;
          vnd_balance_q <= (vnd_st == ST_AVAILABLE) ? amount_q - {8'd0, exec_cost} : amount_q;
          if (vnd_st == ST_AVAILABLE) vnd_product_q <= item_q;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.sup_ready   = sup_rdy;
  assign bus.vnd_ready   = vnd_rdy;
  assign bus.sup_done    = sup_done_q;
  assign bus.sup_err     = sup_err_q;
  assign bus.vnd_done    = vnd_done_q;
  assign bus.vnd_status  = vnd_status_q;
  assign bus.vnd_balance = vnd_balance_q;
  assign bus.vnd_product = vnd_product_q;

  vm2002_stock_table #(.NUM_ITEMS(NUM_ITEMS), .CNT_W(CNT_W)) u_table (
    .clk        (clk),
    .rst_n      (hrst_n),
    .wr_en      (wr_en),
    .wr_item    (item_q),
    .wr_count   (wr_count),
    .wr_cost    (wr_cost),
    .exec_item  (item_q),
    .exec_count (exec_count),
    .exec_cost  (exec_cost),
    .qry_item   (qry_item),
    .qry_count  (qry_count),
    .qry_cost   (qry_cost)
  );

endmodule

// File: tb/tb_vm2002_stock_arbiter.sv
// Bench for the stock arbiter: stimulus pushes hand-computed results into
// per-port queues, a monitor pops and compares on each done pulse.
module tb_vm2002_stock_arbiter;
  import vm2002_pkg::*;

  logic clk = 1'b0;
  logic hrst_n = 1'b0;
  always #5 clk = ~clk;

  vm2002_stock_arbiter_if bus();
  logic [2:0] qry_item;
  logic [4:0] qry_count;
  logic [7:0] qry_cost;

  vm2002_stock_arbiter dut (
    .clk       (clk),
    .hrst_n    (hrst_n),
    .bus       (bus),
    .qry_item  (qry_item),
    .qry_count (qry_count),
    .qry_cost  (qry_cost)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {logic err; int due;} sexp_t;
  typedef struct {logic [1:0] st; logic [15:0] bal; logic [2:0] prod; int due;} vexp_t;
  sexp_t sup_q[$];
  vexp_t vnd_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not match expectation (cycle %0d)", nm, cyc);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  sexp_t se;
  vexp_t ve;
  always @(negedge clk) begin
    if (bus.sup_done === 1'b1) begin
      if (sup_q.size() == 0) fail_evt("sup_done_unexpected");
      else begin
        se = sup_q.pop_front();
        chk("sup_latency", 32'(cyc), 32'(se.due));
        chk("sup_err", 32'(bus.sup_err), 32'(se.err));
      end
    end
    if (bus.vnd_done === 1'b1) begin
      if (vnd_q.size() == 0) fail_evt("vnd_done_unexpected");
      else begin
        ve = vnd_q.pop_front();
        chk("vnd_latency", 32'(cyc), 32'(ve.due));
        chk("vnd_status", 32'(bus.vnd_status), 32'(ve.st));
        chk("vnd_balance", 32'(bus.vnd_balance), 32'(ve.bal));
        chk("vnd_product", 32'(bus.vnd_product), 32'(ve.prod));
      end
    end
  end

  task automatic do_sup(input logic [2:0] it, input logic [3:0] c, input logic [7:0] cost,
                        input logic err);
    int n = 0;
    @(negedge clk);
    bus.sup_item = it; bus.sup_count = c; bus.sup_cost = cost; bus.sup_valid = 1'b1;
    #1;
    while (!bus.sup_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!bus.sup_ready) fail_evt("sup_accept_timeout");
    else sup_q.push_back('{err, cyc + 2});
    @(posedge clk); #1;
    bus.sup_valid = 1'b0;
  endtask

  task automatic do_vnd(input logic [2:0] it, input logic [15:0] amt, input status_e st,
                        input logic [15:0] bal, input logic [2:0] prod);
    int n = 0;
    @(negedge clk);
    bus.vnd_item = it; bus.vnd_amount = amt; bus.vnd_valid = 1'b1;
    #1;
    while (!bus.vnd_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!bus.vnd_ready) fail_evt("vnd_accept_timeout");
    else vnd_q.push_back('{st, bal, prod, cyc + 2});
    @(posedge clk); #1;
    bus.vnd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sup_q.size() != 0 || vnd_q.size() != 0) && n < 20) begin
      @(negedge clk); #2; n++;
    end
    if (sup_q.size() != 0 || vnd_q.size() != 0) begin
      fail_evt("done_timeout");
      sup_q.delete();
      vnd_q.delete();
    end
  endtask

  task automatic qchk(input logic [2:0] it, input logic [4:0] c, input logic [7:0] cost);
    @(negedge clk);
    qry_item = it;
    #1;
    chk("qry_count", 32'(qry_count), 32'(c));
    chk("qry_cost", 32'(qry_cost), 32'(cost));
  endtask

  task automatic chk_outputs_zero();
    chk("rst_sup_done", 32'(bus.sup_done), 0);
    chk("rst_sup_err", 32'(bus.sup_err), 0);
    chk("rst_vnd_done", 32'(bus.vnd_done), 0);
    chk("rst_vnd_status", 32'(bus.vnd_status), 0);
    chk("rst_vnd_balance", 32'(bus.vnd_balance), 0);
    chk("rst_vnd_product", 32'(bus.vnd_product), 0);
  endtask

  int s, v, g, gid, n;
  logic gs, gv;
  int order[4];

  initial begin
    bus.sup_valid = 0; bus.sup_item = 0; bus.sup_count = 0; bus.sup_cost = 0;
    bus.vnd_valid = 0; bus.vnd_item = 0; bus.vnd_amount = 0;
    qry_item = 0;
    order[0] = 0; order[1] = 1; order[2] = 0; order[3] = 1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk_outputs_zero();
    qry_item = 3'd1; #1;
    chk("rst_qry_count", 32'(qry_count), 0);
    chk("rst_qry_cost", 32'(qry_cost), 0);
    @(negedge clk); hrst_n = 1'b1;

    // Restock basics and overflow boundary
    do_sup(SODA, 4'd5, 8'd75, 1'b0);  drain(); qchk(SODA, 5'd5, 8'd75);
    do_sup(SODA, 4'd7, 8'd0, 1'b0);   drain(); qchk(SODA, 5'd12, 8'd75);
    do_sup(SODA, 4'd5, 8'd99, 1'b1);  drain(); qchk(SODA, 5'd12, 8'd75);
    do_sup(SODA, 4'd4, 8'd0, 1'b0);   drain(); qchk(SODA, 5'd16, 8'd75);
    do_sup(COFFEE, 4'd15, 8'd10, 1'b0); drain(); qchk(COFFEE, 5'd15, 8'd10);
    do_sup(COFFEE, 4'd1, 8'd0, 1'b0);   drain(); qchk(COFFEE, 5'd16, 8'd10);

    // Purchases: success, exact change, insufficient, unpriced, out of stock
    do_vnd(SODA, 16'd100, ST_AVAILABLE, 16'd25, SODA); drain(); qchk(SODA, 5'd15, 8'd75);
    do_vnd(SODA, 16'd75, ST_AVAILABLE, 16'd0, SODA);   drain(); qchk(SODA, 5'd14, 8'd75);
    do_vnd(SODA, 16'd50, ST_INSUFFICIENT, 16'd50, SODA); drain(); qchk(SODA, 5'd14, 8'd75);
    do_vnd(TEA, 16'd100, ST_ERROR, 16'd100, SODA); drain();
    do_sup(JUICE, 4'd0, 8'd40, 1'b0); drain(); qchk(JUICE, 5'd0, 8'd40);
    do_vnd(JUICE, 16'd60, ST_OUT_OF_STOCK, 16'd60, SODA); drain(); qchk(JUICE, 5'd0, 8'd40);

    // Contention from reset: order sup, vnd, sup, vnd
    @(negedge clk); hrst_n = 1'b0;
    @(negedge clk); hrst_n = 1'b1;
    @(negedge clk);
    bus.sup_item = CHIPS; bus.sup_count = 4'd3; bus.sup_cost = 8'd20; bus.sup_valid = 1'b1;
    bus.vnd_item = CHIPS; bus.vnd_amount = 16'd30; bus.vnd_valid = 1'b1;
    s = 0; v = 0; g = 0;
    for (int k = 0; k < 40 && (s < 2 || v < 2); k++) begin
      #1;
      gs = bus.sup_ready;
      gv = bus.vnd_ready;
      chk("dual_ready", 32'(gs && gv), 0);
      if ((gs || gv) && g < 4) begin
        gid = gs ? 0 : 1;
        chk("grant_order", 32'(gid), 32'(order[g]));
        g++;
      end
      if (gs) sup_q.push_back('{1'b0, cyc + 2});
      else if (gv) begin
        if (v == 0) vnd_q.push_back('{ST_AVAILABLE, 16'd10, CHIPS, cyc + 2});
        else        vnd_q.push_back('{ST_AVAILABLE, 16'd0, CHIPS, cyc + 2});
      end
      @(posedge clk); #1;
      if (gs) begin
        s++;
        if (s == 1) begin bus.sup_count = 4'd2; bus.sup_cost = 8'd0; end
        else bus.sup_valid = 1'b0;
      end else if (gv) begin
        v++;
        if (v == 1) bus.vnd_amount = 16'd20;
        else bus.vnd_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.sup_valid = 1'b0; bus.vnd_valid = 1'b0;
    if (s < 2 || v < 2) fail_evt("contention_timeout");
    drain();
    qchk(CHIPS, 5'd3, 8'd20);

    // Reset while a purchase is executing
    do_sup(CANDY, 4'd2, 8'd50, 1'b0); drain();
    @(negedge clk);
    bus.vnd_item = CANDY; bus.vnd_amount = 16'd50; bus.vnd_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.vnd_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!bus.vnd_ready) fail_evt("vnd_accept_timeout");
    @(posedge clk); #1;
    bus.vnd_valid = 1'b0;
    @(negedge clk);
    hrst_n = 1'b0;
    #1;
    chk_outputs_zero();
    qry_item = CANDY; #1;
    chk("rst_qry_count", 32'(qry_count), 0);
    chk("rst_qry_cost", 32'(qry_cost), 0);
    repeat (2) @(negedge clk);
    hrst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("post_rst_vnd_done", 32'(bus.vnd_done), 0);
    do_sup(CANDY, 4'd1, 8'd30, 1'b0); drain(); qchk(CANDY, 5'd1, 8'd30);
    do_vnd(CANDY, 16'd45, ST_AVAILABLE, 16'd15, CANDY); drain(); qchk(CANDY, 5'd0, 8'd30);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vm2002_stock_arbiter.md
Name: vm2002_stock_arbiter

Overview:
Owns the vending machine's item-count and item-price tables and shares them between two requesters: the supplier restock port and the vend engine purchase port. Serialises both requesters through a small FSM with fair tie-breaking and performs read-modify-write on the tables. Returns a status, balance and product code for each purchase, and an error flag for each restock. Sits between the supplier interface and the vend FSM, replacing any direct table access by either side.

Parameters:
NUM_ITEMS, 8, number of item slots (item codes 0..NUM_ITEMS-1)
MAX_COUNT, 16, maximum stock per item
CNT_W, 5, width of a count entry; must satisfy 2**CNT_W > MAX_COUNT

Ports:
clk  in  1  clock
hrst_n  in  1  asynchronous active-low reset
sup_valid  in  1  restock request
sup_item  in  3  item code to restock
sup_count  in  4  units to add
sup_cost  in  8  new price; 0 keeps the current price
sup_ready  out  1  restock request accepted this cycle
sup_done  out  1  one-cycle restock completion pulse
sup_err  out  1  restock rejected (overflow or bad item); valid while sup_done is high, held until the next sup_done
vnd_valid  in  1  purchase request
vnd_item  in  3  item code selected
vnd_amount  in  16  credit inserted, in cents
vnd_ready  out  1  purchase request accepted this cycle
vnd_done  out  1  one-cycle purchase completion pulse
vnd_status  out  2  purchase result (status_e); held until the next vnd_done
vnd_balance  out  16  change due or credit retained; held
vnd_product  out  3  item dispensed; updated on success only
qry_item  in  3  table read address
qry_count  out  CNT_W  count[qry_item], combinational
qry_cost  out  8  cost[qry_item], combinational

Behaviour:
- Reset (hrst_n low, asynchronous):
  - state IDLE; all counts 0; all costs 0.
  - All outputs 0; prio = supplier.
  - Any in-flight operation is discarded and no done pulse is issued.
- FSM states: IDLE, SUP_EXEC, VND_EXEC.
- Arbitration and handshake, in IDLE only:
  - Only sup_valid high: sup_ready=1.
  - Only vnd_valid high: vnd_ready=1.
  - Both high: grant the requester selected by prio, then toggle prio to the other requester.
  - A single-requester grant sets prio to the other requester.
  - Both ready outputs are combinational; both are 0 outside IDLE.
- Acceptance is valid&&ready. On the accepting edge, latch item/count/cost/amount and go to the matching EXEC state. A requester must hold its request fields stable while valid and not ready, and drops valid after acceptance.
- SUP_EXEC, after one cycle, returns to IDLE. On that edge:
  - sum = count[item] + sup_count, computed at CNT_W+1 bits.
  - If item >= NUM_ITEMS or sum > MAX_COUNT: sup_err=1; count and cost unchanged.
  - Otherwise: count[item]=sum; cost[item]=sup_cost if sup_cost != 0; sup_err=0.
  - sup_done=1 for the next cycle.
- VND_EXEC, after one cycle, returns to IDLE. Checks in priority order:
  - item >= NUM_ITEMS or cost[item]==0 -> ST_ERROR, balance=amount.
  - count[item]==0 -> ST_OUT_OF_STOCK, balance=amount.
  - amount < cost (cost zero-extended to 16 bits) -> ST_INSUFFICIENT, balance=amount.
  - Otherwise -> ST_AVAILABLE, count[item] decremented, balance=amount-cost, product=item.
  - vnd_done=1 for the next cycle.
- Latency: accept in cycle A, done high in cycle A+2. IDLE is re-entered in cycle A+2, so a new accept is possible in the same cycle done is high.
- Operations are strictly serialised; a purchase granted after a restock sees the updated tables.
- amount == cost is a success with balance 0.
- count never underflows: the count==0 check precedes the decrement.
- Query port reflects a table write from the cycle after the write edge.

Decomposition:
- Package vm2002_pkg gains:
  - status_e enum: ST_AVAILABLE=0, ST_OUT_OF_STOCK=1, ST_INSUFFICIENT=2, ST_ERROR=3.
  - arb_state_e enum (IDLE, SUP_EXEC, VND_EXEC).
  - Item code constants WATER..COOKIE = 0..7.
- Sub-module vm2002_stock_table: NUM_ITEMS x {count, cost} register file with one write port and two combinational read ports (exec and query).
- Arbitration, FSM and arithmetic stay in vm2002_stock_arbiter.

Test Plan:
1. Reset, restock item 1 count 5 cost 8'd75 -> sup_done in cycle A+2; sup_err=0; qry_item=1 gives count 5, cost 75.
2. Item 1 at count 12, restock count 5 -> sup_err=1; count stays 12. Then restock count 4 -> sup_err=0, count 16.
3. Item 1 at cost 75, count 16: purchase amount 100 -> ST_AVAILABLE, balance 25, product 1, count 15. Then purchase amount 75 -> balance 0.
4. Purchase item 1 with amount 50 -> ST_INSUFFICIENT, balance 50, count unchanged. Purchase unpriced item 3 -> ST_ERROR. Purchase priced item with count 0 -> ST_OUT_OF_STOCK.
5. sup_valid and vnd_valid high together for 4 operations from reset -> grant order sup, vnd, sup, vnd; never both ready in one cycle.
6. hrst_n low during VND_EXEC -> no vnd_done; table cleared; all outputs 0; next request served normally.
